// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared widths, port ids and helpers for the data-memory arbiter
package dm_pkg;

    localparam int DM_DW = 32;
    localparam int DM_AW = 10;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
    endfunction

    function automatic logic [1:0] port_onehot(input port_id_t p);
        return (p == PORT_CPU) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and memory-side signal bundle of the data-memory arbiter
interface dm_arbiter_if
    import dm_pkg::*;
#(
    parameter int DW = DM_DW,
    parameter int AW = DM_AW
);

    logic          p0_valid;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ready;
    logic          p0_rsp_valid;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p0_lock;

    logic          p1_valid;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ready;
    logic          p1_rsp_valid;
    logic [DW-1:0] p1_rsp_rdata;
    logic          p1_lock;

    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
        output p0_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
        output p1_ready, p1_rsp_valid, p1_rsp_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory view.
    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
        input  p0_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
        input  p1_ready, p1_rsp_valid, p1_rsp_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rtl/dm_arbiter_rr_arb2.sv - stateless two-way round-robin grant selection
module rr_arb2
    import dm_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = port_onehot(prio);
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter for the single-port data memory; optional burst lock via DM_ARB_LOCK_EN
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DW = DM_DW,
    parameter int AW = DM_AW
) (
    input  logic       clk,
    input  logic       rst_n,
    dm_arbiter_if.slave bus
);

    port_id_t      prio;
    logic          rsp_pending;
    port_id_t      rsp_owner;

    logic [1:0]    req;
    logic [1:0]    rr_gnt;
    logic [1:0]    gnt;
    logic          granted;
    logic          lock_hold;
    port_id_t      winner;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          rd_grant;

    // Requests are masked while reset is held so no ready leaks out.
    assign req = {bus.p1_valid, bus.p0_valid} & {2{rst_n}};

    rr_arb2 u_rr (
        .req  (req),
        .prio (prio),
        .gnt  (rr_gnt)
    );

`ifdef DM_ARB_LOCK_EN
    logic     lock_owner_valid;
    port_id_t lock_owner;
    logic     win_lock;

    assign lock_hold = lock_owner_valid && req[lock_owner];
    assign gnt       = lock_hold ? port_onehot(lock_owner) : rr_gnt;
    assign win_lock  = gnt[1] ? bus.p1_lock : bus.p0_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_owner_valid <= 1'b0;
            lock_owner       <= PORT_CPU;
        end else begin
            lock_owner_valid <= granted && win_lock;
            if (granted) begin
                lock_owner <= winner;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = bus.p0_lock ^ bus.p1_lock;
    assign lock_hold   = 1'b0;
    assign gnt         = rr_gnt;
`endif

    assign granted   = |gnt;
    assign winner    = gnt[1] ? PORT_DBG : PORT_CPU;
    assign win_we    = gnt[1] ? bus.p1_we    : bus.p0_we;
    assign win_addr  = gnt[1] ? bus.p1_addr  : bus.p0_addr;
    assign win_wdata = gnt[1] ? bus.p1_wdata : bus.p0_wdata;
    assign rd_grant  = granted && !win_we;

    assign bus.p0_ready  = gnt[0];
    assign bus.p1_ready  = gnt[1];
    assign bus.mem_rd_en = rd_grant;
    assign bus.mem_wr_en = granted && win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;

    // Memory read data lands one cycle after the grant; steer it to whoever issued it.
    assign bus.p0_rsp_valid = rsp_pending && (rsp_owner == PORT_CPU);
    assign bus.p1_rsp_valid = rsp_pending && (rsp_owner == PORT_DBG);
    assign bus.p0_rsp_rdata = bus.p0_rsp_valid ? bus.mem_rdata : '0;
    assign bus.p1_rsp_rdata = bus.p1_rsp_valid ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio        <= PORT_CPU;
            rsp_pending <= 1'b0;
            rsp_owner   <= PORT_CPU;
        end else begin
            rsp_pending <= rd_grant;
            if (rd_grant) begin
                rsp_owner <= winner;
            end
            if (granted && !lock_hold) begin
                prio <= other_port(winner);
            end
        end
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory (1024 x 32, registered read, one access per cycle).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Grants the memory port by round-robin, drives mem_rd_en/mem_wr_en/mem_addr/mem_wdata, and routes each read response back to its issuer one cycle later.
- Fully pipelined: one access accepted per cycle.

Parameters:
- DW, 32, data width
- AW, 10, word address width (memory depth 2**AW)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- p0_valid  in  1  port 0 request valid
- p0_we  in  1  port 0: 1 = write, 0 = read
- p0_addr  in  AW  port 0 word address
- p0_wdata  in  DW  port 0 write data
- p0_ready  out  1  port 0 request accepted this cycle
- p0_rsp_valid  out  1  port 0 read data valid
- p0_rsp_rdata  out  DW  port 0 read data
- p1_valid / p1_we / p1_addr / p1_wdata / p1_ready / p1_rsp_valid / p1_rsp_rdata  same as port 0, for port 1
- p0_lock  in  1  port 0 burst lock (DM_ARB_LOCK_EN only)
- p1_lock  in  1  port 1 burst lock (DM_ARB_LOCK_EN only)
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_rd_en

Behaviour:
- Reset (async, rst_n low):
  - prio = port 0; rsp_pending = 0; rsp_owner = 0.
  - All ready and rsp_valid outputs are 0; mem_rd_en and mem_wr_en are 0.
- Arbitration (combinational, same cycle):
  - If only one port is valid, that port wins.
  - If both are valid, the port equal to prio wins.
  - Winner's pN_ready = 1; the loser's ready = 0.
  - The loser must hold valid, we, addr and wdata stable until it is accepted.
- Priority update (registered): after any grant, prio <= other port. With no grant, prio is unchanged.
- Memory drive:
  - Grant with we = 0: mem_rd_en = 1.
  - Grant with we = 1: mem_wr_en = 1.
  - mem_rd_en and mem_wr_en are never both 1.
  - No grant: both enables are 0. mem_addr and mem_wdata follow the winner, or port 0 when idle.
- Response path:
  - On a read grant: rsp_pending <= 1 and rsp_owner <= winner; otherwise rsp_pending <= 0.
  - pN_rsp_valid = rsp_pending && rsp_owner == N.
  - pN_rsp_rdata = mem_rdata when valid, else 0.
  - Read latency is exactly 1 cycle after the ready cycle.
- Writes:
  - Complete at the grant edge and produce no response.
  - A read to the same address granted in the next cycle returns the new data.
- Back-to-back: a new grant is allowed in the same cycle a response is returned; there is no bubble.
- No response back-pressure: requesters must always sink pN_rsp_valid.
- Reset mid-operation: any pending response is dropped and rsp_valid does not fire after reset release.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1...

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- Defined:
  - When the previous grant went to port N with pN_lock = 1 and pN_valid = 1 this cycle, port N wins regardless of prio, and prio does not advance.
  - The lock releases when pN_lock is low at grant time or pN_valid drops.
  - Lock inputs are ignored for a port that did not win the previous grant.
  - This adds a 1-bit lock_owner_valid register and a 1-bit lock_owner register, both reset to 0.
- Undefined:
  - p0_lock and p1_lock are still present but unused.
  - Pure round-robin applies.

Decomposition:
- Package dm_pkg:
  - DM_DW = 32, DM_AW = 10.
  - Port-id typedef (1 bit: PORT_CPU = 0, PORT_DBG = 1).
- Sub-module rr_arb2:
  - Pure 2-way round-robin: req[1:0], prio in, gnt[1:0] out.
  - Lock and priority registers stay in dm_arbiter.

Test Plan:
- Reset then idle: all outputs 0. Single p0 read of addr 0x005 after a prior p0 write of 0x1234_5678 -> p0_ready the same cycle; p0_rsp_valid = 1 with rdata 0x1234_5678 exactly one cycle later; p1_rsp_valid stays 0.
- Both ports valid reads for 4 cycles (p0 addr 0x010, p1 addr 0x020, preloaded 0xA, 0xB) -> grants 0,1,0,1; responses alternate 0xA to p0, 0xB to p1, each 1 cycle after its grant.
- Same cycle: p0 write 0x3FF = 0xDEAD_BEEF, p1 read 0x3FF, prio = 0 -> p0 is granted first; p1 is granted next cycle and receives 0xDEAD_BEEF; mem_rd_en and mem_wr_en are never both high.
- rst_n asserted in the cycle after a p1 read grant -> p1_rsp_valid never asserts; prio = 0 after release.
- DM_ARB_LOCK_EN, both valid, p1 wins with p1_lock = 1 for 3 requests -> 3 consecutive p1 grants; after p1_lock drops, p0 is granted next.
- Write-only traffic on p0, 8 cycles, addresses 0..7 -> no rsp_valid on either port; a readback of 0..7 returns the written data.
